// File: rtl/regfile_op_sequencer.sv
// Multi-cycle operation sequencer for a 4-entry register file.
// It reads two operands, then executes ADD, SUB, MOV or an iterative shift-add MUL,
// writes the result back and pulses done once the write has landed.
module regfile_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [1:0]       rs1,
  input  logic [1:0]       rs2,
  input  logic [1:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       readRegister1,
  output logic [1:0]       readRegister2,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  output logic [1:0]       writeRegister,
  output logic             writeEnable,
  output logic [WIDTH-1:0] writeData
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpMov = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } stateType;

  stateType         state;
  stateType         nextState;
  logic [1:0]       opReg;
  logic [1:0]       rs1Reg;
  logic [1:0]       rs2Reg;
  logic [1:0]       rdReg;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] acc;
  logic [3:0]       count;
  logic [WIDTH-1:0] resultReg;
  logic             doneReg;

  // State register; reset drops any operation in flight straight back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode; MUL stays in EXEC for all 16 shift-add steps
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = READ;
      READ:    nextState = EXEC;
      EXEC:    if ((opReg != OpMul) || (count == 4'd15)) nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state and latched registers only, never from start
  always_comb begin
    busy          = (state != IDLE);
    writeEnable   = (state == WRITE);
    readRegister1 = rs1Reg;
    readRegister2 = rs2Reg;
    writeRegister = rdReg;
    writeData     = acc;
    result        = resultReg;
    done          = doneReg;
  end

  // Datapath: request latch, operand capture, execution and result writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg     <= '0;
      rs1Reg    <= '0;
      rs2Reg    <= '0;
      rdReg     <= '0;
      opA       <= '0;
      opB       <= '0;
      acc       <= '0;
      count     <= '0;
      resultReg <= '0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= (state == WRITE);
      case (state)
        IDLE: begin
          if (start) begin
            opReg  <= opcode;
            rs1Reg <= rs1;
            rs2Reg <= rs2;
            rdReg  <= rd;
          end
        end
        READ: begin
          opA   <= readData1;
          opB   <= readData2;
          acc   <= '0;
          count <= '0;
        end
        EXEC: begin
          case (opReg)
            OpAdd: acc <= opA + opB;
            OpSub: acc <= opA - opB;
            OpMov: acc <= opA;
            OpMul: begin
              if (opB[0]) acc <= acc + opA;
              opA   <= opA << 1;
              opB   <= opB >> 1;
              count <= count + 4'd1;
            end
            default: acc <= acc;
          endcase
        end
        WRITE: begin
          resultReg <= acc;
        end
        default: begin
          resultReg <= resultReg;
        end
      endcase
    end
  end

endmodule
